// File: rtl/write_data_burst_serializer_pkg.sv
// Shared constants and state type for the write-data drain path that feeds the DQ bus.
package write_data_burst_serializer_pkg;

    localparam int BACKEND_WORD_SIZE = 64;
    localparam int WR_BURST_LEN      = 8;
    localparam int WR_WRITE_LATENCY  = 5;

    typedef enum logic {
        WS_IDLE  = 1'b0,
        WS_BURST = 1'b1
    } wr_ser_state_t;

endpackage

// File: rtl/write_data_burst_serializer.sv
// Pops one backend word per WRITE issue after the DRAM write latency and streams it
// onto DQ as a framed burst, LSB beat first. Flags underflow and burst overlap (sticky).
module write_data_burst_serializer
    import write_data_burst_serializer_pkg::*;
#(
    parameter int DATA_WIDTH    = BACKEND_WORD_SIZE,
    parameter int BURST_LEN     = WR_BURST_LEN,
    parameter int WRITE_LATENCY = WR_WRITE_LATENCY
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_wr_issue,
    input  logic [DATA_WIDTH-1:0]            i_fifo_data,
    input  logic                             i_fifo_empty,
    output logic                             o_fifo_rd_en,
    output logic [DATA_WIDTH/BURST_LEN-1:0]  o_dq,
    output logic                             o_dq_valid,
    output logic                             o_dq_first,
    output logic                             o_dq_last,
    output logic                             o_busy,
    output logic                             o_underflow,
    output logic                             o_overlap_err
);

    localparam int DQ_WIDTH = DATA_WIDTH / BURST_LEN;
    localparam int CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int DL_W     = WRITE_LATENCY - 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    wr_ser_state_t          state_r;
    logic [DL_W-1:0]        delay_line_r;
    logic [CNT_W-1:0]       beat_cnt_r;
    logic [DATA_WIDTH-1:0]  sreg_r;

    logic                   fetch_s;
    logic                   at_last_s;
    logic                   slot_free_s;
    logic                   accept_s;
    logic                   overlap_s;
    logic [CNT_W-1:0]       next_cnt_s;
    logic [DATA_WIDTH-1:0]  load_word_s;

    // Fetch arbitration: a new burst may start only from idle or on the final beat.
    always_comb begin
        fetch_s     = delay_line_r[DL_W-1];
        at_last_s   = (state_r == WS_BURST) && (beat_cnt_r == LAST_BEAT);
        slot_free_s = (state_r == WS_IDLE) || at_last_s;
        accept_s    = fetch_s && slot_free_s;
        overlap_s   = fetch_s && !slot_free_s;
        next_cnt_s  = beat_cnt_r + 1'b1;
        if (i_fifo_empty) begin
            load_word_s = '0;
        end else begin
            load_word_s = i_fifo_data;
        end
        o_fifo_rd_en = accept_s && !i_fifo_empty;
        o_busy       = (state_r == WS_BURST) || (|delay_line_r) || i_wr_issue;
    end

    // Latency delay line, burst FSM, beat framing and sticky error flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r       <= WS_IDLE;
            delay_line_r  <= '0;
            beat_cnt_r    <= '0;
            sreg_r        <= '0;
            o_dq          <= '0;
            o_dq_valid    <= 1'b0;
            o_dq_first    <= 1'b0;
            o_dq_last     <= 1'b0;
            o_underflow   <= 1'b0;
            o_overlap_err <= 1'b0;
        end else begin
            delay_line_r <= (delay_line_r << 1'b1) | DL_W'(i_wr_issue);
            if (overlap_s) begin
                o_overlap_err <= 1'b1;
            end
            if (accept_s && i_fifo_empty) begin
                o_underflow <= 1'b1;
            end
            // The first beat is presented straight from the fetched word so that DQ
            // starts exactly WRITE_LATENCY cycles after the issue.
            if (accept_s) begin
                state_r    <= WS_BURST;
                beat_cnt_r <= '0;
                o_dq       <= load_word_s[DQ_WIDTH-1:0];
                sreg_r     <= load_word_s >> DQ_WIDTH;
                o_dq_valid <= 1'b1;
                o_dq_first <= 1'b1;
                o_dq_last  <= (LAST_BEAT == '0);
            end else if ((state_r == WS_BURST) && !at_last_s) begin
                beat_cnt_r <= next_cnt_s;
                o_dq       <= sreg_r[DQ_WIDTH-1:0];
                sreg_r     <= sreg_r >> DQ_WIDTH;
                o_dq_valid <= 1'b1;
                o_dq_first <= 1'b0;
                o_dq_last  <= (next_cnt_s == LAST_BEAT);
            end else begin
                state_r    <= WS_IDLE;
                beat_cnt_r <= '0;
                sreg_r     <= '0;
                o_dq       <= '0;
                o_dq_valid <= 1'b0;
                o_dq_first <= 1'b0;
                o_dq_last  <= 1'b0;
            end
        end
    end

endmodule
